// File: rtl/spi_pkt_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkt_pkg
// Shared definitions for the SPI packet controller: FSM state encoding,
// packet type codes, the sync byte returned at the start of every SPI
// transaction, and a helper that assembles the status byte.
// ---------------------------------------------------------------------------
package spi_pkt_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TYPE,
        ST_LEN_H,
        ST_LEN_L,
        ST_SPACE_H,
        ST_SPACE_L,
        ST_SEL,
        ST_DIVR,
        ST_DIVF,
        ST_DATA,
        ST_DRAIN,
        ST_STATUS
    } state_t;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;

    localparam logic [7:0] PKT_GET_SPACE  = 8'd0;
    localparam logic [7:0] PKT_SET_FREQ   = 8'd1;
    localparam logic [7:0] PKT_FIFO_DATA  = 8'd2;
    localparam logic [7:0] PKT_GET_STATUS = 8'd3;

    // Status byte layout: {4'b0, overflow, bad_pkt, full, empty}
    function automatic logic [7:0] status_byte(input logic ovf, input logic bad,
                                               input logic full, input logic empty);
        return {4'b0000, ovf, bad, full, empty};
    endfunction

endpackage

// File: rtl/pkt_len_cnt.sv
// ---------------------------------------------------------------------------
// pkt_len_cnt
// 16-bit payload length down-counter.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (takes priority over dec)
//   load_val  : new count
//   dec       : decrement by one (holds at zero)
//   zero      : count is zero
//   last      : count is one, i.e. the next decrement empties it
// ---------------------------------------------------------------------------
module pkt_len_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    output logic        zero,
    output logic        last
);

    logic [15:0] count;

    // Load wins over decrement; decrement never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 16'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 16'd0)) begin
            count <= count - 16'd1;
        end
    end

    assign zero = (count == 16'd0);
    assign last = (count == 16'd1);

endmodule

// File: rtl/spi_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// spi_pkt_ctrl
// Decodes packets received over SPI (type, 16-bit length, payload) and
// dispatches them: FIFO space query, synthesizer divider writes, FIFO data
// writes and status readback.
//   clk, rst              : clock, synchronous active-high reset
//   spi_tsx_start         : start of SPI transaction (aborts any packet)
//   spi_rx_data/_stb      : received byte and its one-cycle strobe
//   spi_tx_data           : byte to shift out on the next SPI byte
//   fifo_space_free/full/empty : FIFO status inputs
//   fifo_wr_data, fifo_wr : FIFO write port (one-cycle pulse)
//   freq_sel, freq_data   : synthesizer channel and divider value
//   freq_wr_divr/_divf    : divider write pulses
//   err_overflow          : sticky, a payload byte hit a full FIFO
//   err_bad_pkt           : sticky, unknown type or channel out of range
// All outputs are registered; write pulses appear the cycle after the strobe.
// ---------------------------------------------------------------------------
module spi_pkt_ctrl
    import spi_pkt_pkg::*;
#(
    parameter  int FIFO_AW   = 12,
    parameter  int NUM_SYNTH = 2,
    localparam int CH_W      = (NUM_SYNTH > 1) ? $clog2(NUM_SYNTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_tsx_start,
    input  logic [7:0]         spi_rx_data,
    input  logic               spi_rx_stb,
    output logic [7:0]         spi_tx_data,
    input  logic [FIFO_AW-1:0] fifo_space_free,
    input  logic               fifo_full,
    input  logic               fifo_empty,
    output logic [7:0]         fifo_wr_data,
    output logic               fifo_wr,
    output logic [CH_W-1:0]    freq_sel,
    output logic [7:0]         freq_data,
    output logic               freq_wr_divr,
    output logic               freq_wr_divf,
    output logic               err_overflow,
    output logic               err_bad_pkt
);

    state_t      state, state_d;
    logic [7:0]  pkt_type, pkt_type_d;
    logic [7:0]  len_h, len_h_d;
    logic [15:0] space_snap, space_snap_d;
    logic [15:0] space_ext;
    logic [7:0]  tx_d;
    logic [7:0]  fifo_wr_data_d;
    logic        fifo_wr_d;
    logic [CH_W-1:0] freq_sel_d;
    logic [7:0]  freq_data_d;
    logic        divr_d, divf_d;
    logic        ovf_set, bad_set, flag_clr;
    logic        cnt_load, cnt_dec, cnt_zero, cnt_last;

    assign space_ext = 16'(fifo_space_free);

    pkt_len_cnt u_len_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val ({len_h, spi_rx_data}),
        .dec      (cnt_dec),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    // State and output registers. Sticky flags resolve a simultaneous
    // set and clear as set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            pkt_type     <= 8'd0;
            len_h        <= 8'd0;
            space_snap   <= 16'd0;
            spi_tx_data  <= 8'd0;
            fifo_wr_data <= 8'd0;
            fifo_wr      <= 1'b0;
            freq_sel     <= '0;
            freq_data    <= 8'd0;
            freq_wr_divr <= 1'b0;
            freq_wr_divf <= 1'b0;
            err_overflow <= 1'b0;
            err_bad_pkt  <= 1'b0;
        end else begin
            state        <= state_d;
            pkt_type     <= pkt_type_d;
            len_h        <= len_h_d;
            space_snap   <= space_snap_d;
            spi_tx_data  <= tx_d;
            fifo_wr_data <= fifo_wr_data_d;
            fifo_wr      <= fifo_wr_d;
            freq_sel     <= freq_sel_d;
            freq_data    <= freq_data_d;
            freq_wr_divr <= divr_d;
            freq_wr_divf <= divf_d;
            err_overflow <= ovf_set | (err_overflow & ~flag_clr);
            err_bad_pkt  <= bad_set | (err_bad_pkt & ~flag_clr);
        end
    end

    // Next-state and next-output logic. A transaction start overrides any
    // byte strobe in the same cycle; bytes only advance the FSM on a strobe.
    always_comb begin
        state_d        = state;
        pkt_type_d     = pkt_type;
        len_h_d        = len_h;
        space_snap_d   = space_snap;
        tx_d           = spi_tx_data;
        fifo_wr_data_d = fifo_wr_data;
        fifo_wr_d      = 1'b0;
        freq_sel_d     = freq_sel;
        freq_data_d    = freq_data;
        divr_d         = 1'b0;
        divf_d         = 1'b0;
        ovf_set        = 1'b0;
        bad_set        = 1'b0;
        flag_clr       = 1'b0;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;

        if (spi_tsx_start) begin
            state_d = ST_TYPE;
            tx_d    = SYNC_BYTE;
        end else if (spi_rx_stb) begin
            case (state)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_TYPE: begin
                    pkt_type_d = spi_rx_data;
                    state_d    = ST_LEN_H;
                end
                ST_LEN_H: begin
                    len_h_d = spi_rx_data;
                    state_d = ST_LEN_L;
                end
                ST_LEN_L: begin
                    case (pkt_type)
                        PKT_GET_SPACE: begin
                            space_snap_d = space_ext;
                            tx_d         = space_ext[15:8];
                            state_d      = ST_SPACE_H;
                        end
                        PKT_SET_FREQ: begin
                            state_d = ST_SEL;
                        end
                        PKT_FIFO_DATA: begin
                            cnt_load = 1'b1;
                            state_d  = ({len_h, spi_rx_data} == 16'd0) ? ST_IDLE : ST_DATA;
                        end
                        PKT_GET_STATUS: begin
                            tx_d     = status_byte(err_overflow, err_bad_pkt, fifo_full, fifo_empty);
                            flag_clr = 1'b1;
                            state_d  = ST_STATUS;
                        end
                        default: begin
                            bad_set = 1'b1;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
                ST_SPACE_H: begin
                    tx_d    = space_snap[7:0];
                    state_d = ST_SPACE_L;
                end
                ST_SPACE_L: begin
                    state_d = ST_IDLE;
                end
                ST_SEL: begin
                    if (int'(spi_rx_data) < NUM_SYNTH) begin
                        freq_sel_d = spi_rx_data[CH_W-1:0];
                        state_d    = ST_DIVR;
                    end else begin
                        bad_set = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_DIVR: begin
                    freq_data_d = spi_rx_data;
                    divr_d      = 1'b1;
                    state_d     = ST_DIVF;
                end
                ST_DIVF: begin
                    freq_data_d = spi_rx_data;
                    divf_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
                ST_DATA: begin
                    // The host sees the free space of the FIFO while streaming.
                    cnt_dec = 1'b1;
                    tx_d    = space_ext[7:0];
                    if (!fifo_full) begin
                        fifo_wr_data_d = spi_rx_data;
                        fifo_wr_d      = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                    if (cnt_last || cnt_zero) begin
                        state_d = ST_IDLE;
                    end else if (fifo_full) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    cnt_dec = 1'b1;
                    if (cnt_last || cnt_zero) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STATUS: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_pkt_ctrl
// Self-checking bench for spi_pkt_ctrl. Packets are built from a small
// behavioural model: expected FIFO writes, divider writes, readback bytes and
// sticky flags follow directly from the packet contents.
// ---------------------------------------------------------------------------
module tb_spi_pkt_ctrl;
    import spi_pkt_pkg::*;

    localparam int FIFO_AW   = 12;
    localparam int NUM_SYNTH = 2;
    localparam int CH_W      = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               spi_tsx_start;
    logic [7:0]         spi_rx_data;
    logic               spi_rx_stb;
    logic [7:0]         spi_tx_data;
    logic [FIFO_AW-1:0] fifo_space_free;
    logic               fifo_full;
    logic               fifo_empty;
    logic [7:0]         fifo_wr_data;
    logic               fifo_wr;
    logic [CH_W-1:0]    freq_sel;
    logic [7:0]         freq_data;
    logic               freq_wr_divr;
    logic               freq_wr_divf;
    logic               err_overflow;
    logic               err_bad_pkt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic       m_ovf, m_bad;
    logic [7:0] m_sel, m_fdata;

    // Observed pulses
    logic [7:0] cap_fifo[$];
    logic [7:0] cap_divr[$];
    logic [7:0] cap_divf[$];

    spi_pkt_ctrl #(.FIFO_AW(FIFO_AW), .NUM_SYNTH(NUM_SYNTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .spi_tsx_start   (spi_tsx_start),
        .spi_rx_data     (spi_rx_data),
        .spi_rx_stb      (spi_rx_stb),
        .spi_tx_data     (spi_tx_data),
        .fifo_space_free (fifo_space_free),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .fifo_wr_data    (fifo_wr_data),
        .fifo_wr         (fifo_wr),
        .freq_sel        (freq_sel),
        .freq_data       (freq_data),
        .freq_wr_divr    (freq_wr_divr),
        .freq_wr_divf    (freq_wr_divf),
        .err_overflow    (err_overflow),
        .err_bad_pkt     (err_bad_pkt)
    );

    always #5 clk = ~clk;

    // Each high cycle of a pulse is recorded once, so a stuck pulse shows up
    // as extra entries.
    always @(negedge clk) begin
        if (fifo_wr)      cap_fifo.push_back(fifo_wr_data);
        if (freq_wr_divr) cap_divr.push_back(freq_data);
        if (freq_wr_divf) cap_divf.push_back(freq_data);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        spi_tsx_start = 1'b1;
        @(negedge clk);
        spi_tsx_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        spi_rx_data = b;
        spi_rx_stb  = 1'b1;
        @(negedge clk);
        spi_rx_stb  = 1'b0;
        spi_rx_data = 8'($urandom);
        tick($urandom_range(0, 1));
    endtask

    task automatic send_hdr(input logic [7:0] ptype, input logic [15:0] len);
        pulse_start();
        send_byte(ptype);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        spi_rx_stb = 1'b1;
        spi_tsx_start = 1'b1;
        tick(2);
        spi_rx_stb = 1'b0;
        spi_tsx_start = 1'b0;
        m_ovf = 1'b0; m_bad = 1'b0; m_sel = 8'd0; m_fdata = 8'd0;
        n_cmp++;
        if ({spi_tx_data, fifo_wr_data, fifo_wr, freq_sel, freq_data,
             freq_wr_divr, freq_wr_divf, err_overflow, err_bad_pkt} !== 30'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got tx=%0h wd=%0h wr=%0b sel=%0h fd=%0h r=%0b f=%0b ovf=%0b bad=%0b, expected all zero",
                     spi_tx_data, fifo_wr_data, fifo_wr, freq_sel, freq_data,
                     freq_wr_divr, freq_wr_divf, err_overflow, err_bad_pkt);
        end
        n_cmp++;
        if (dut.state !== ST_IDLE) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state, ST_IDLE);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_set_freq(input logic [7:0] ch, input logic [7:0] dr, input logic [7:0] df);
        int exp_n;
        cap_divr.delete();
        cap_divf.delete();
        send_hdr(PKT_SET_FREQ, 16'h0003);
        send_byte(ch);
        send_byte(dr);
        send_byte(df);
        tick(2);
        if (int'(ch) < NUM_SYNTH) begin
            exp_n = 1; m_sel = ch; m_fdata = df;
        end else begin
            exp_n = 0; m_bad = 1'b1;
        end
        n_cmp++;
        if (cap_divr.size() !== exp_n || cap_divf.size() !== exp_n) begin
            n_fail++;
            $display("[TB] FAIL freq_pulse_count: got divr=%0d divf=%0d expected %0d each",
                     cap_divr.size(), cap_divf.size(), exp_n);
        end else if (exp_n == 1) begin
            n_cmp++;
            if (cap_divr[0] !== dr || cap_divf[0] !== df) begin
                n_fail++;
                $display("[TB] FAIL freq_data: got divr=%0h divf=%0h expected %0h %0h",
                         cap_divr[0], cap_divf[0], dr, df);
            end
        end
        n_cmp++;
        if (freq_sel !== m_sel[CH_W-1:0] || freq_data !== m_fdata) begin
            n_fail++;
            $display("[TB] FAIL freq_regs: got sel=%0h data=%0h expected %0h %0h",
                     freq_sel, freq_data, m_sel[CH_W-1:0], m_fdata);
        end
        n_cmp++;
        if (err_bad_pkt !== m_bad || dut.state !== ST_IDLE) begin
            n_fail++;
            $display("[TB] FAIL freq_end: got bad=%0b state=%0d expected bad=%0b state=%0d",
                     err_bad_pkt, dut.state, m_bad, ST_IDLE);
        end
    endtask

    // full_at: index of the first payload byte presented with fifo_full high
    task automatic test_fifo_data(input int len, input int full_at);
        logic [7:0] payload[$];
        logic [7:0] exp_q[$];
        for (int i = 0; i < len; i++) payload.push_back(8'($urandom));
        cap_fifo.delete();
        fifo_full = 1'b0;
        send_hdr(PKT_FIFO_DATA, 16'(len));
        for (int i = 0; i < len; i++) begin
            fifo_full = (i >= full_at);
            send_byte(payload[i]);
            if (i < full_at) exp_q.push_back(payload[i]);
            else m_ovf = 1'b1;
        end
        fifo_full = 1'b0;
        tick(2);
        n_cmp++;
        if (cap_fifo.size() !== exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL fifo_write_count: got %0d expected %0d (len=%0d full_at=%0d)",
                     cap_fifo.size(), exp_q.size(), len, full_at);
        end
        for (int i = 0; i < exp_q.size() && i < cap_fifo.size(); i++) begin
            n_cmp++;
            if (cap_fifo[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL fifo_write_data[%0d]: got %0h expected %0h", i, cap_fifo[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (err_overflow !== m_ovf || dut.state !== ST_IDLE) begin
            n_fail++;
            $display("[TB] FAIL fifo_end: got ovf=%0b state=%0d expected ovf=%0b state=%0d",
                     err_overflow, dut.state, m_ovf, ST_IDLE);
        end
    endtask

    task automatic test_get_space(input logic [FIFO_AW-1:0] space);
        logic [15:0] ext;
        ext = 16'(space);
        fifo_space_free = space;
        send_hdr(PKT_GET_SPACE, 16'h0000);
        fifo_space_free = FIFO_AW'($urandom);
        n_cmp++;
        if (spi_tx_data !== ext[15:8]) begin
            n_fail++;
            $display("[TB] FAIL space_high: got %0h expected %0h", spi_tx_data, ext[15:8]);
        end
        send_byte(8'($urandom));
        n_cmp++;
        if (spi_tx_data !== ext[7:0]) begin
            n_fail++;
            $display("[TB] FAIL space_low: got %0h expected %0h", spi_tx_data, ext[7:0]);
        end
        send_byte(8'($urandom));
        n_cmp++;
        if (dut.state !== ST_IDLE) begin
            n_fail++;
            $display("[TB] FAIL space_end: got state %0d expected %0d", dut.state, ST_IDLE);
        end
    endtask

    task automatic test_status(input logic full, input logic empty);
        logic [7:0] exp_b;
        fifo_full  = full;
        fifo_empty = empty;
        exp_b = {4'b0000, m_ovf, m_bad, full, empty};
        send_hdr(PKT_GET_STATUS, 16'h0000);
        fifo_full  = 1'b0;
        fifo_empty = 1'b0;
        m_ovf = 1'b0;
        m_bad = 1'b0;
        n_cmp++;
        if (spi_tx_data !== exp_b) begin
            n_fail++;
            $display("[TB] FAIL status_byte: got %0h expected %0h", spi_tx_data, exp_b);
        end
        n_cmp++;
        if (err_overflow !== 1'b0 || err_bad_pkt !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL status_clear: got ovf=%0b bad=%0b expected 0 0", err_overflow, err_bad_pkt);
        end
        send_byte(8'($urandom));
        n_cmp++;
        if (dut.state !== ST_IDLE) begin
            n_fail++;
            $display("[TB] FAIL status_end: got state %0d expected %0d", dut.state, ST_IDLE);
        end
    endtask

    task automatic test_bad_type(input logic [7:0] t);
        send_hdr(t, 16'($urandom));
        m_bad = 1'b1;
        n_cmp++;
        if (err_bad_pkt !== 1'b1 || dut.state !== ST_IDLE) begin
            n_fail++;
            $display("[TB] FAIL bad_type: got bad=%0b state=%0d expected bad=1 state=%0d",
                     err_bad_pkt, dut.state, ST_IDLE);
        end
    endtask

    task automatic test_abort_and_reset();
        logic [7:0] p0, p1, x;
        p0 = 8'($urandom); p1 = 8'($urandom); x = 8'($urandom);
        cap_fifo.delete();
        fifo_full = 1'b0;
        send_hdr(PKT_FIFO_DATA, 16'd4);
        send_byte(p0);
        send_byte(p1);
        pulse_start();
        n_cmp++;
        if (spi_tx_data !== SYNC_BYTE || dut.state !== ST_TYPE) begin
            n_fail++;
            $display("[TB] FAIL abort: got tx=%0h state=%0d expected tx=%0h state=%0d",
                     spi_tx_data, dut.state, SYNC_BYTE, ST_TYPE);
        end
        send_byte(PKT_FIFO_DATA);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(x);
        tick(2);
        n_cmp++;
        if (cap_fifo.size() !== 3 || cap_fifo[0] !== p0 || cap_fifo[1] !== p1 || cap_fifo[2] !== x) begin
            n_fail++;
            $display("[TB] FAIL abort_writes: got %p expected [%0h %0h %0h]", cap_fifo, p0, p1, x);
        end
        // Reset in the middle of a draining packet with a flag set
        send_hdr(PKT_FIFO_DATA, 16'd5);
        fifo_full = 1'b1;
        send_byte(8'($urandom));
        fifo_full = 1'b0;
        n_cmp++;
        if (err_overflow !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_ovf: got %0b expected 1", err_overflow);
        end
        test_reset();
        cap_fifo.delete();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 4))
                0: test_set_freq(8'($urandom_range(0, 2)), 8'($urandom), 8'($urandom));
                1: test_fifo_data($urandom_range(0, 6), $urandom_range(0, 8));
                2: test_get_space(FIFO_AW'($urandom));
                3: test_status(1'($urandom), 1'($urandom));
                default: test_bad_type(8'($urandom_range(4, 255)));
            endcase
        end
    endtask

    initial begin
        rst = 1'b1;
        spi_tsx_start = 1'b0;
        spi_rx_data = 8'd0;
        spi_rx_stb = 1'b0;
        fifo_space_free = '0;
        fifo_full = 1'b0;
        fifo_empty = 1'b0;

        test_reset();
        test_set_freq(8'd1, 8'h12, 8'h34);
        test_fifo_data(4, 99);
        test_fifo_data(4, 2);
        test_fifo_data(0, 99);
        test_get_space(12'hABC);
        test_status(1'b0, 1'b0);
        test_bad_type(8'd7);
        test_status(1'b0, 1'b0);
        test_set_freq(8'd5, 8'h55, 8'h66);
        test_abort_and_reset();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_pkt_ctrl.md
SPI_PKT_CTRL -- requirements
Module: spi_pkt_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_AW, default 12, meaning FIFO space-count width (legal range 1..16).
REQ-002 The block SHALL have parameter NUM_SYNTH, default 2, meaning number of frequency synthesizers addressed; CH_W = max(1, clog2(NUM_SYNTH)).
REQ-003 The block SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- spi_tsx_start  in  1  SPI transaction start pulse
- spi_rx_data  in  8  received byte
- spi_rx_stb  in  1  spi_rx_data valid, one-cycle pulse
- spi_tx_data  out  8  next byte to shift out
- fifo_space_free  in  FIFO_AW  free FIFO entries
- fifo_full  in  1  FIFO full
- fifo_empty  in  1  FIFO empty
- fifo_wr_data  out  8  FIFO write data
- fifo_wr  out  1  FIFO write pulse
- freq_sel  out  CH_W  synthesizer channel index
- freq_data  out  8  divider value
- freq_wr_divr  out  1  DIVR write pulse
- freq_wr_divf  out  1  DIVF write pulse
- err_overflow  out  1  sticky: FIFO byte dropped
- err_bad_pkt  out  1  sticky: illegal type or channel

Function
REQ-004 Packet format SHALL be: type byte, length high byte, length low byte (16-bit LEN), then payload; every byte is consumed only on spi_rx_stb.
REQ-005 States SHALL be IDLE, TYPE, LEN_H, LEN_L, SPACE_H, SPACE_L, SEL, DIVR, DIVF, DATA, DRAIN, STATUS.
REQ-006 In IDLE, spi_tsx_start SHALL load spi_tx_data=0xA5 and move to TYPE.
REQ-007 spi_tsx_start in any non-IDLE state SHALL abort the packet, load 0xA5, and go to TYPE; in-flight pulses already registered still complete.
REQ-008 On LEN_L strobe, type 0 (GET_SPACE) SHALL snapshot fifo_space_free zero-extended to 16 bits, load its high byte into spi_tx_data, and go to SPACE_H.
REQ-009 SPACE_H strobe SHALL load the snapshot low byte and go to SPACE_L; SPACE_L strobe SHALL return to IDLE.
REQ-010 Type 1 (SET_FREQ) SHALL go to SEL; SEL strobe with byte < NUM_SYNTH SHALL latch freq_sel and go to DIVR, otherwise set err_bad_pkt and go to IDLE.
REQ-011 DIVR strobe SHALL drive freq_data=byte and pulse freq_wr_divr one cycle, next state DIVF; DIVF strobe SHALL do likewise with freq_wr_divf, then IDLE.
REQ-012 Type 2 (FIFO_DATA) SHALL load a 16-bit down-counter with LEN; LEN=0 SHALL return directly to IDLE.
REQ-013 In DATA each strobe SHALL decrement the counter; if fifo_full is low, fifo_wr_data=byte and fifo_wr pulses one cycle later; if fifo_full is high, no write occurs, err_overflow sets and state becomes DRAIN.
REQ-014 DRAIN SHALL consume and discard bytes, decrementing the counter, with no writes.
REQ-015 DATA or DRAIN SHALL return to IDLE on the strobe that brings the counter to 0.
REQ-016 In DATA, spi_tx_data SHALL be loaded with fifo_space_free[7:0] on each strobe.
REQ-017 Type 3 (GET_STATUS) SHALL load spi_tx_data={4'b0, err_overflow, err_bad_pkt, fifo_full, fifo_empty}, clear both sticky flags in that same cycle, go to STATUS; STATUS strobe returns to IDLE.
REQ-018 Type > 3 SHALL set err_bad_pkt and return to IDLE after LEN_L.
REQ-019 fifo_wr, freq_wr_divr and freq_wr_divf SHALL be single-cycle pulses, deasserted by default every cycle.
REQ-020 Sticky error set and clear in the same cycle SHALL resolve as set.

Reset
REQ-021 rst SHALL force IDLE and zero every output, counter, snapshot and sticky flag, overriding all other events, including mid-packet.

Structure
REQ-022 State encodings, packet type codes (0..3) and the 0xA5 sync byte SHALL live in shared package spi_pkt_pkg.
REQ-023 The 16-bit length down-counter with load/decrement/zero flag SHALL be sub-module pkt_len_cnt.

Verification
REQ-024 Bench SHALL cover start, type 1, LEN 0x0003, channel 1, 0x12, 0x34 -> freq_sel=1; freq_wr_divr pulse with 0x12; freq_wr_divf pulse with 0x34; IDLE.
REQ-025 Bench SHALL cover type 2, LEN 0x0004, four bytes, fifo_full low -> exactly four fifo_wr pulses with matching data; IDLE.
REQ-026 Bench SHALL cover type 2, LEN 4, fifo_full high after byte 2 -> two writes; err_overflow=1; bytes 3-4 drained; IDLE.
REQ-027 Bench SHALL cover type 0 with fifo_space_free=0xABC -> spi_tx_data 0x0A then 0xBC.
REQ-028 Bench SHALL cover type 7, then type 3 -> err_bad_pkt=1; status byte 0x04 with empty/full low; flag cleared afterwards.
REQ-029 Bench SHALL cover spi_tsx_start during DATA with 2 bytes left, and rst mid-packet -> TYPE with 0xA5; outputs all zero, IDLE.
